// File: rtl/noc_pkg.sv
// Shared NoC definitions.
// Holds the traffic generator state encoding and the packet counter width so
// the generator, the sink and any benches agree on both.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } tg_state_e;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Stream packet source for a NoC ingress port.
// A START pulse launches a run of NUM_PKTS packets of PKT_LEN beats each.
// Payloads describe themselves: TDATA = {packet index, beat index}, with each
// half zero-extended or truncated to TDATAW/2 bits. TDEST walks up from
// DEST_BASE, one step per packet, and wraps at 2^TDESTW.
//
// Ports
//   CLK            clock, rising edge
//   RST            synchronous active-high reset
//   START          one-cycle run request, honoured only in IDLE
//   BUSY           run in progress (SEND or GAP)
//   DONE           sticky run-complete flag, cleared by the next START or RST
//   PKT_CNT        packets fully sent in the current run
//   AXIS_M_*       AXI-Stream master channel, all outputs registered
//   DBG_STATE      current FSM state, for checkers
//
// Handshake: a beat transfers on a rising edge where TVALID and TREADY are
// both 1. Once TVALID is raised, it and TDATA/TLAST/TID/TDEST hold steady
// until that transfer happens. Only RST can cut a beat short. TVALID never
// depends on TREADY in the same cycle.
module axis_traffic_gen
  import noc_pkg::*;
#(
  parameter int TDATAW     = 32,
  parameter int TDESTW     = 4,
  parameter int TIDW       = 2,
  parameter int SRC_ID     = 0,
  parameter int PKT_LEN    = 4,
  parameter int NUM_PKTS   = 8,
  parameter int DEST_BASE  = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [PKT_CNT_W-1:0] PKT_CNT,
  output logic                 AXIS_M_TVALID,
  input  logic                 AXIS_M_TREADY,
  output logic [TDATAW-1:0]    AXIS_M_TDATA,
  output logic                 AXIS_M_TLAST,
  output logic [TIDW-1:0]      AXIS_M_TID,
  output logic [TDESTW-1:0]    AXIS_M_TDEST,
  output tg_state_e            DBG_STATE
);

  localparam int          HALFW     = TDATAW / 2;
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);
  localparam logic [15:0] LAST_PKT  = 16'(NUM_PKTS - 1);
  // The gap counter counts down to zero inclusive, so loading GAP_CYCLES-1
  // gives exactly GAP_CYCLES idle cycles.
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES - 1);

  tg_state_e              state_q, state_d;
  logic [15:0]            beat_q, beat_d;
  logic [15:0]            pkt_q, pkt_d;
  logic [7:0]             gap_q, gap_d;
  logic [PKT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   tvalid_q, tvalid_d;
  logic [TDATAW-1:0]      tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic [TIDW-1:0]        tid_q, tid_d;
  logic [TDESTW-1:0]      tdest_q, tdest_d;
  logic                   hs;

  assign hs = tvalid_q && AXIS_M_TREADY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      pkt_q    <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tid_q    <= '0;
      tdest_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tid_q    <= tid_d;
      tdest_q  <= tdest_d;
    end
  end

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          beat_d  = '0;
          pkt_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (beat_q == LAST_BEAT) begin
            cnt_d = cnt_q + 1'b1;
            if (pkt_q == LAST_PKT) begin
              done_d  = 1'b1;
              state_d = FIN;
            end else begin
              beat_d = '0;
              pkt_d  = pkt_q + 1'b1;
              if (GAP_CYCLES > 0) begin
                gap_d   = GAP_LOAD;
                state_d = GAP;
              end
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = SEND;
        else             gap_d   = gap_q - 1'b1;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register inputs, built from the next counter values so a new beat
  // is presented the edge after the previous handshake with no bubble. The
  // cycle right after START is spent loading the first beat, so TVALID rises
  // one edge after BUSY.
  always_comb begin
    busy_d   = (state_d == SEND) || (state_d == GAP);
    tvalid_d = (state_d == SEND) && (state_q != IDLE);
    tdata_d  = '0;
    tlast_d  = 1'b0;
    tid_d    = '0;
    tdest_d  = '0;
    if (tvalid_d) begin
      tdata_d = {HALFW'(pkt_d), HALFW'(beat_d)};
      tlast_d = (beat_d == LAST_BEAT);
      tid_d   = TIDW'(SRC_ID);
      tdest_d = TDESTW'(DEST_BASE) + TDESTW'(pkt_d);
    end
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign PKT_CNT       = cnt_q;
  assign AXIS_M_TVALID = tvalid_q;
  assign AXIS_M_TDATA  = tdata_q;
  assign AXIS_M_TLAST  = tlast_q;
  assign AXIS_M_TID    = tid_q;
  assign AXIS_M_TDEST  = tdest_q;
  assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Bench for axis_traffic_gen: three instances covering the default
// configuration, inter-packet gaps, and single-beat packets with TDEST wrap.
module tb_axis_traffic_gen;
  import noc_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- u0: defaults ----------------
  logic        start0, tready0, busy0, done0, tvalid0, tlast0;
  logic [15:0] cnt0;
  logic [31:0] tdata0;
  logic [1:0]  tid0;
  logic [3:0]  tdest0;
  tg_state_e   st0;
  logic [38:0] cur0;
  assign cur0 = {tid0, tlast0, tdest0, tdata0};

  axis_traffic_gen u0 (
    .CLK(CLK), .RST(RST), .START(start0), .BUSY(busy0), .DONE(done0),
    .PKT_CNT(cnt0), .AXIS_M_TVALID(tvalid0), .AXIS_M_TREADY(tready0),
    .AXIS_M_TDATA(tdata0), .AXIS_M_TLAST(tlast0), .AXIS_M_TID(tid0),
    .AXIS_M_TDEST(tdest0), .DBG_STATE(st0)
  );

  // ---------------- u1: gaps ----------------
  logic        start1, tready1, busy1, done1, tvalid1, tlast1;
  logic [15:0] cnt1;
  logic [31:0] tdata1;
  logic [1:0]  tid1;
  logic [3:0]  tdest1;
  tg_state_e   st1;

  axis_traffic_gen #(.PKT_LEN(2), .NUM_PKTS(3), .GAP_CYCLES(3)) u1 (
    .CLK(CLK), .RST(RST), .START(start1), .BUSY(busy1), .DONE(done1),
    .PKT_CNT(cnt1), .AXIS_M_TVALID(tvalid1), .AXIS_M_TREADY(tready1),
    .AXIS_M_TDATA(tdata1), .AXIS_M_TLAST(tlast1), .AXIS_M_TID(tid1),
    .AXIS_M_TDEST(tdest1), .DBG_STATE(st1)
  );

  // ---------------- u2: single-beat packets, narrow TDEST ----------------
  logic        start2, tready2, busy2, done2, tvalid2, tlast2;
  logic [15:0] cnt2;
  logic [31:0] tdata2;
  logic [1:0]  tid2;
  logic [1:0]  tdest2;
  tg_state_e   st2;

  axis_traffic_gen #(.TDESTW(2), .DEST_BASE(3), .NUM_PKTS(6), .PKT_LEN(1)) u2 (
    .CLK(CLK), .RST(RST), .START(start2), .BUSY(busy2), .DONE(done2),
    .PKT_CNT(cnt2), .AXIS_M_TVALID(tvalid2), .AXIS_M_TREADY(tready2),
    .AXIS_M_TDATA(tdata2), .AXIS_M_TLAST(tlast2), .AXIS_M_TID(tid2),
    .AXIS_M_TDEST(tdest2), .DBG_STATE(st2)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- scoreboard for u0 ----------------
  logic [38:0] exp_q[$];
  logic [32:0] exp1_q[$];
  logic [33:0] exp2_q[$];
  logic [38:0] held;
  logic        stalled = 1'b0;
  int          last_hs_cyc = 0;

  always @(negedge CLK) begin
    if (RST) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", 64'({tvalid0, cur0}), 64'({1'b1, held}));
      if (tvalid0 && tready0) begin
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) check("beat_expected", 64'(exp_q.size()), 64'd1);
        else                   check("beat", 64'(cur0), 64'(exp_q.pop_front()));
      end
      stalled = tvalid0 && !tready0;
      held    = cur0;
    end
  end

  // ---------------- drivers ----------------
  logic rnd_mode = 1'b0;
  always @(posedge CLK) begin
    if (rnd_mode) begin
      #1;
      tready0 = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_run0();
    for (int p = 0; p < 8; p++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back({2'b00, (b == 3), 4'(p), 16'(p), 16'(b)});
  endtask

  task automatic start0_run();
    @(posedge CLK); #1;
    start0 = 1'b1;
    push_run0();
    @(posedge CLK); #1;
    start0 = 1'b0;
    check("start_busy", 64'(busy0), 64'd1);
    check("start_done_clr", 64'(done0), 64'd0);
    check("start_cnt_clr", 64'(cnt0), 64'd0);
    check("start_tvalid_lat", 64'(tvalid0), 64'd0);
  endtask

  task automatic wait_done0(input int budget);
    int n = 0;
    while (!done0 && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    check("done_seen", 64'(done0), 64'd1);
    check("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
    check("busy_fall", 64'(busy0), 64'd0);
    check("fin_tvalid", 64'(tvalid0), 64'd0);
    check("pkt_cnt", 64'(cnt0), 64'd8);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RST = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tready0 = 1'b1; tready1 = 1'b1; tready2 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_tvalid", 64'(tvalid0), 64'd0);
    check("rst_payload", 64'(cur0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_cnt", 64'(cnt0), 64'd0);
    check("rst_state", 64'(st0), 64'(IDLE));
    RST = 1'b0;

    // Run 1: TREADY held high, full-rate back-to-back packets.
    start0_run();
    @(posedge CLK); #1;
    check("first_tvalid", 64'(tvalid0), 64'd1);
    check("first_tdata", 64'(tdata0), 64'd0);
    wait_done0(100);

    // Run 2: random backpressure, stray STARTs while busy and in FIN.
    rnd_mode = 1'b1;
    start0_run();
    for (int k = 0; k < 3; k++) begin
      repeat (4) @(posedge CLK);
      #1 start0 = 1'b1;
      @(posedge CLK); #1;
      start0 = 1'b0;
    end
    check("busy_mid_run", 64'(busy0), 64'd1);
    wait_done0(400);
    start0 = 1'b1;
    @(posedge CLK); #1;
    start0 = 1'b0;
    check("fin_start_done", 64'(done0), 64'd1);
    check("fin_start_busy", 64'(busy0), 64'd0);
    check("fin_start_state", 64'(st0), 64'(IDLE));
    rnd_mode = 1'b0;
    #2 tready0 = 1'b1;

    // Run 3: reset while beat 2 of packet 1 is stalled.
    start0_run();
    begin
      int n = 0;
      while (!(tvalid0 && tdata0 == 32'h0001_0002) && n < 50) begin
        @(posedge CLK); #1;
        n++;
      end
    end
    tready0 = 1'b0;
    check("stall_target", 64'(tdata0), 64'h0001_0002);
    check("mid_cnt", 64'(cnt0), 64'd1);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    check("abort_tvalid", 64'(tvalid0), 64'd0);
    check("abort_payload", 64'(cur0), 64'd0);
    check("abort_busy", 64'(busy0), 64'd0);
    check("abort_cnt", 64'(cnt0), 64'd0);
    check("abort_state", 64'(st0), 64'(IDLE));
    RST = 1'b0;
    exp_q.delete();
    tready0 = 1'b1;
    start0_run();
    wait_done0(100);

    // u1: gaps of exactly three idle cycles between packets.
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 2; b++) exp1_q.push_back({1'b1, 16'(p), 16'(b)});
      if (p < 2) repeat (3) exp1_q.push_back({1'b0, 32'd0});
    end
    @(posedge CLK); #1 start1 = 1'b1;
    @(posedge CLK); #1 start1 = 1'b0;
    check("u1_lat", 64'(tvalid1), 64'd0);
    while (exp1_q.size() > 0) begin
      logic [32:0] e;
      @(posedge CLK); #1;
      e = exp1_q.pop_front();
      check("u1_valid", 64'(tvalid1), 64'(e[32]));
      if (e[32]) check("u1_data", 64'(tdata1), 64'(e[31:0]));
    end
    @(posedge CLK); #1;
    check("u1_done", 64'(done1), 64'd1);
    check("u1_cnt", 64'(cnt1), 64'd3);

    // u2: PKT_LEN=1 and TDEST wrapping from base 3 in a 2-bit field.
    for (int p = 0; p < 6; p++) exp2_q.push_back({2'((3 + p) % 4), 16'(p), 16'd0});
    @(posedge CLK); #1 start2 = 1'b1;
    @(posedge CLK); #1 start2 = 1'b0;
    begin
      int n = 0;
      while (exp2_q.size() > 0 && n < 30) begin
        logic [33:0] e;
        @(posedge CLK); #1;
        n++;
        if (tvalid2) begin
          e = exp2_q.pop_front();
          check("u2_tlast", 64'(tlast2), 64'd1);
          check("u2_tdest", 64'(tdest2), 64'(e[33:32]));
          check("u2_tdata", 64'(tdata2), 64'(e[31:0]));
        end
      end
    end
    check("u2_beats_left", 64'(exp2_q.size()), 64'd0);
    @(posedge CLK); #1;
    check("u2_done", 64'(done2), 64'd1);
    check("u2_cnt", 64'(cnt2), 64'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_traffic_gen.md
# axis_traffic_gen

AXI-Stream packet source that injects a deterministic stream of multi-beat packets into the NoC. It is the transmit-side counterpart of the NoC output sink, which logs every flit it receives and flags DONE on TLAST. It sits at a NoC ingress port and is started by the testbench or top level. Its payloads are self-describing, so the sink's log can be checked beat-for-beat.

## Interface
- TDATAW, 32: data width; even, ≥ 16
- TDESTW, 4: destination field width
- TIDW, 2: ID field width
- SRC_ID, 0: constant driven on TID, TIDW bits
- PKT_LEN, 4: beats per packet, 1..65535
- NUM_PKTS, 8: packets per run, 1..65535
- DEST_BASE, 0: TDEST of packet 0
- GAP_CYCLES, 0: idle cycles between packets, 0..255
---
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  one-cycle run request
- BUSY  out  1  high from the cycle after an accepted START until the last handshake
- DONE  out  1  sticky run-complete flag
- PKT_CNT  out  16  packets fully sent in the current run
- AXIS_M_TVALID  out  1
- AXIS_M_TREADY  in  1
- AXIS_M_TDATA  out  TDATAW
- AXIS_M_TLAST  out  1
- AXIS_M_TID  out  TIDW
- AXIS_M_TDEST  out  TDESTW

## Operation
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - START=1 clears pkt/beat counters, PKT_CNT and DONE, then goes to SEND.
  - START=0 stays in IDLE.
- SEND:
  - TVALID=1.
  - Handshake: TVALID&&TREADY.
  - Beat on a handshake, not last: beat+1.
  - Last beat of a non-final packet: beat←0, pkt+1, PKT_CNT+1, then GAP if GAP_CYCLES>0, else stay in SEND with no bubble.
  - Last beat of the final packet: PKT_CNT+1, go to FIN.
- GAP:
  - TVALID=0 for exactly GAP_CYCLES cycles (down-counter), then SEND.
- FIN:
  - DONE=1, BUSY=0, next state IDLE.
  - DONE stays high until the next accepted START or RST.
- Payload per beat:
  - TDATA = {pkt[TDATAW/2-1:0], beat[TDATAW/2-1:0]}, counters zero-extended or truncated to TDATAW/2.
  - TDEST = (DEST_BASE + pkt) mod 2^TDESTW, wrapping silently.
  - TID = SRC_ID.
  - TLAST = (beat == PKT_LEN-1).
- START outside IDLE is ignored. START in the FIN cycle is ignored.
- All AXIS outputs are registered. No combinational path from TREADY to any output.

## Timing
- Reset values, one edge after RST=1:
  - TVALID, TLAST, TDATA, TID, TDEST all 0.
  - BUSY=0, DONE=0, PKT_CNT=0.
  - State IDLE, counters 0.
- Latency: START at edge n gives TVALID=1 with beat 0 of packet 0 valid after edge n+1.
- Backpressure:
  - While TVALID=1 and TREADY=0, TDATA, TLAST, TID and TDEST stay stable.
  - TVALID never deasserts without a handshake, except on RST.
- Throughput: one beat per cycle while TREADY=1 and GAP_CYCLES=0. This includes back-to-back packets.
- PKT_LEN=1: every beat has TLAST=1.
- TREADY low for an arbitrary number of cycles: no beats are lost or duplicated.
- RST mid-packet: everything is aborted next edge, with TVALID=0 even if TREADY=0. No partial-packet recovery.
- RST and START in the same cycle: RST wins.
- DONE rises one cycle after the final handshake.
- BUSY falls in the same cycle that DONE rises.

## Structure
- Shared package noc_pkg holds:
  - the state enum tg_state_e (IDLE, SEND, GAP, FIN),
  - localparam PKT_CNT_W=16.
- Single module; no sub-module is warranted.
- The FSM, the three counters (beat, pkt, gap) and the output register all live in this module.

## Test plan
- Defaults, TREADY=1, one START:
  - 32 consecutive beats.
  - TDATA 0x00000000..0x00000003, then 0x00010000.., up to 0x00070003.
  - TDEST 0..7, TLAST on every 4th beat.
  - DONE rises on the cycle after the last beat; PKT_CNT=8.
- TREADY toggled in a pseudo-random pattern (~50%):
  - The sink sees exactly the 32 expected beats in order, with no duplicates.
  - Outputs are stable during every stall.
- GAP_CYCLES=3, PKT_LEN=2, NUM_PKTS=3:
  - Exactly 3 TVALID-low cycles between the TLAST handshake and the next packet's first beat.
- TDESTW=2, DEST_BASE=3, NUM_PKTS=6:
  - TDEST sequence 3,0,1,2,3,0.
- RST asserted during beat 2 of packet 1 with TREADY=0:
  - All outputs 0 next cycle.
  - A new START replays from 0x00000000.
- START pulsed while BUSY: no effect on the sequence or counters.
- A second START after DONE: DONE clears and the full run repeats.
